// File: rtl/seg7_char_pacer_pkg.sv
// rtl/seg7_char_pacer_pkg.sv - shared types and constants for the seven-segment character pacer
package seg7_char_pacer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Bit positions inside a glyph byte, logical polarity (1 = segment lit)
  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam logic [7:0] GLYPH_BLANK = 8'h00;
  localparam logic [7:0] GLYPH_DASH  = 8'h40;

endpackage

// File: rtl/seg7_char_pacer_if.sv
// rtl/seg7_char_pacer_if.sv - valid/ready character handshake between generator and pacer
interface seg7_char_pacer_if;

  logic [7:0] in_char;
  logic       in_valid;
  logic       in_ready;

  modport master (
    output in_char,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_char,
    input  in_valid,
    output in_ready
  );

endinterface

// File: rtl/seg7_char_pacer_ascii_to_seg7.sv
// rtl/seg7_char_pacer_ascii_to_seg7.sv - combinational ASCII to seven-segment glyph decoder
module ascii_to_seg7
  import seg7_char_pacer_pkg::*;
(
  input  logic [7:0] in_char,
  output logic [7:0] glyph
);

  logic [7:0] upper;

  // Fold lower case onto upper case, then look up the glyph; unknown bytes show a dash
  always_comb begin
    upper = in_char;
    if (in_char >= 8'h61 && in_char <= 8'h7A) begin
      upper = in_char - 8'h20;
    end
    glyph = GLYPH_DASH;
    case (upper)
      8'h20: glyph = GLYPH_BLANK;
      8'h2D: glyph = GLYPH_DASH;
      8'h2E: begin
        glyph         = GLYPH_BLANK;
        glyph[SEG_DP] = 1'b1;
      end
      8'h30: glyph = 8'h3F;
      8'h31: glyph = 8'h06;
      8'h32: glyph = 8'h5B;
      8'h33: glyph = 8'h4F;
      8'h34: glyph = 8'h66;
      8'h35: glyph = 8'h6D;
      8'h36: glyph = 8'h7D;
      8'h37: glyph = 8'h07;
      8'h38: glyph = 8'h7F;
      8'h39: glyph = 8'h6F;
      8'h41: glyph = 8'h77;  // A
      8'h42: glyph = 8'h7C;  // b
      8'h43: glyph = 8'h39;  // C
      8'h44: glyph = 8'h5E;  // d
      8'h45: glyph = 8'h79;  // E
      8'h46: glyph = 8'h71;  // F
      8'h47: glyph = 8'h3D;  // G
      8'h48: glyph = 8'h76;  // H
      8'h49: glyph = 8'h30;  // I
      8'h4A: glyph = 8'h1E;  // J
      8'h4B: glyph = 8'h75;  // K
      8'h4C: glyph = 8'h38;  // L
      8'h4D: glyph = 8'h37;  // M
      8'h4E: glyph = 8'h54;  // n
      8'h4F: glyph = 8'h3F;  // O
      8'h50: glyph = 8'h73;  // P
      8'h51: glyph = 8'h67;  // q
      8'h52: glyph = 8'h50;  // r
      8'h53: glyph = 8'h6D;  // S
      8'h54: glyph = 8'h78;  // t
      8'h55: glyph = 8'h3E;  // U
      8'h56: glyph = 8'h1C;  // v
      8'h57: glyph = 8'h2A;  // W
      8'h58: glyph = 8'h76;  // X
      8'h59: glyph = 8'h6E;  // y
      8'h5A: glyph = 8'h5B;  // Z
      default: glyph = GLYPH_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_char_pacer.sv
// rtl/seg7_char_pacer.sv - paces ASCII characters onto a seven-segment display with dwell and gap
module seg7_char_pacer
  import seg7_char_pacer_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES   = 12_000_000,
  parameter int unsigned GAP_CYCLES     = 1_200_000,
  parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              flush,
  seg7_char_pacer_if.slave  up,
  output logic [7:0]        seg_out,
  output logic              busy
);

  localparam int unsigned CNT_MAX = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
  localparam int          CW      = $clog2(CNT_MAX + 1);

  // Counters are loaded with length-1 so the terminal cycle is the one where cnt reads 0
  localparam logic [CW-1:0] DWELL_LOAD = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD   = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic [7:0]    seg_reg;
  logic [7:0]    seg_next;
  logic          busy_next;
  logic          ready;
  logic          accept;
  logic [7:0]    glyph;

  ascii_to_seg7 u_dec (
    .in_char (up.in_char),
    .glyph   (glyph)
  );

  assign ready       = (state == ST_IDLE) & ena & ~flush;
  assign accept      = up.in_valid & ready;
  assign up.in_ready = ready;

  // Next-state, counter and glyph selection; flush overrides everything, ena low freezes
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    seg_next   = seg_reg;
    if (flush) begin
      state_next = ST_IDLE;
      cnt_next   = '0;
      seg_next   = GLYPH_BLANK;
    end else if (ena) begin
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            state_next = ST_SHOW;
            cnt_next   = DWELL_LOAD;
            seg_next   = glyph;
          end
        end
        ST_SHOW: begin
          if (cnt == '0) begin
            if (GAP_CYCLES > 0) begin
              state_next = ST_GAP;
              cnt_next   = GAP_LOAD;
              seg_next   = GLYPH_BLANK;
            end else begin
              // No gap: glyph stays on the display while idle
              state_next = ST_IDLE;
            end
          end else begin
            cnt_next = cnt - CNT_ONE;
          end
        end
        ST_GAP: begin
          if (cnt == '0) begin
            state_next = ST_IDLE;
          end else begin
            cnt_next = cnt - CNT_ONE;
          end
        end
        default: begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end
      endcase
    end
    busy_next = (state_next != ST_IDLE);
  end

  // State, counter and output registers with asynchronous reset to a blank idle display
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      seg_reg <= GLYPH_BLANK;
      busy    <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      seg_reg <= seg_next;
      busy    <= busy_next;
    end
  end

  assign seg_out = SEG_ACTIVE_LOW ? ~seg_reg : seg_reg;

endmodule
